// File: rtl/uart_cmd_frame_tx.sv
// Host-side UART command issuer: expands one accepted command into its frame
// byte sequence and serializes each byte as start / 8 data LSB-first / parity / stop.
module uart_cmd_frame_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_type,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data0,
    input  logic [DATA_WIDTH-1:0] cmd_data1,
    input  logic [3:0]            cmd_fun,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  byte_done,
    output logic                  cmd_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_t;

    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    state_t                state, state_next;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [2:0]            bit_idx, bit_idx_next;
    logic [1:0]            byte_idx, last_idx;
    logic                  accept, bit_last, last_byte, tx_next;
    logic [DATA_WIDTH-1:0] cur_byte, addr_ext, fun_ext;

    cmd_t                  type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data0_q, data1_q;
    logic [3:0]            fun_q;
    logic                  par_en_q, par_typ_q;

    assign cmd_ready = (state == S_IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign bit_last  = (bit_cnt == BIT_LAST);
    assign last_byte = (byte_idx == last_idx);
    assign busy      = (state != S_IDLE);
    assign byte_done = (state == S_STOP) & bit_last;
    assign cmd_done  = byte_done & last_byte;
    assign addr_ext  = DATA_WIDTH'(addr_q);
    assign fun_ext   = DATA_WIDTH'(fun_q);

    // Frame byte selected by the latched command type and the current byte slot.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path infers a latch.
        cur_byte = '0;
        last_idx = 2'd1;
        case (type_q)
            CMD_RF_WR: begin
                last_idx = 2'd2;
                case (byte_idx)
                    2'd0:    cur_byte = DATA_WIDTH'(8'hAA);
                    2'd1:    cur_byte = addr_ext;
                    default: cur_byte = data0_q;
                endcase
            end
            CMD_RF_RD: begin
                cur_byte = (byte_idx == 2'd0) ? DATA_WIDTH'(8'hBB) : addr_ext;
            end
            CMD_ALU_OP: begin
                last_idx = 2'd3;
                case (byte_idx)
                    2'd0:    cur_byte = DATA_WIDTH'(8'hCC);
                    2'd1:    cur_byte = data0_q;
                    2'd2:    cur_byte = data1_q;
                    default: cur_byte = fun_ext;
                endcase
            end
            default: begin
                cur_byte = (byte_idx == 2'd0) ? DATA_WIDTH'(8'hDD) : fun_ext;
            end
        endcase
    end

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        case (state)
            S_IDLE:   if (accept) state_next = S_START;
            S_START:  if (bit_last) state_next = S_DATA;
            S_DATA: begin
                if (bit_last) begin
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_last) state_next = S_STOP;
            S_STOP:   if (bit_last) state_next = last_byte ? S_IDLE : S_START;
            default:  state_next = S_IDLE;
        endcase

        // Line level is decoded from the next state so tx_out is a clean register.
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = cur_byte[bit_idx_next];
            S_PARITY: tx_next = ^cur_byte ^ par_typ_q;
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_out   <= 1'b1;
        end else begin
            state   <= state_next;
            tx_out  <= tx_next;
            bit_idx <= bit_idx_next;
            if (state == S_IDLE) bit_cnt <= '0;
            else                 bit_cnt <= bit_last ? '0 : bit_cnt + CNT_WIDTH'(1);
            if (accept) begin
                byte_idx <= '0;
                bit_idx  <= '0;
            end else if (byte_done && !last_byte) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    // NOTE: command holding registers are only read after an accept loads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            type_q    <= cmd_t'(cmd_type);
            addr_q    <= cmd_addr;
            data0_q   <= cmd_data0;
            data1_q   <= cmd_data1;
            fun_q     <= cmd_fun;
            par_en_q  <= par_en;
            par_typ_q <= par_typ;
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Directed bench for uart_cmd_frame_tx: decodes the serial line per bit period
// and compares bytes, parity, framing and handshake timing to hand-computed values.
module tb_uart_cmd_frame_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data0;
    logic [7:0] cmd_data1;
    logic [3:0] cmd_fun;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;
    logic       byte_done;
    logic       cmd_done;

    int n_vec = 0;
    int n_err = 0;

    uart_cmd_frame_tx #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .CLKS_PER_BIT(CPB),
        .CNT_WIDTH   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_addr  (cmd_addr),
        .cmd_data0 (cmd_data0),
        .cmd_data1 (cmd_data1),
        .cmd_fun   (cmd_fun),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .tx_out    (tx_out),
        .busy      (busy),
        .byte_done (byte_done),
        .cmd_done  (cmd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [3:0] f, input logic pe, input logic pt);
        cmd_type  = t;
        cmd_addr  = a;
        cmd_data0 = d0;
        cmd_data1 = d1;
        cmd_fun   = f;
        par_en    = pe;
        par_typ   = pt;
    endtask

    // Raise cmd_valid, take the accept edge and check the same-edge start bit.
    task automatic issue(input string tag, input bit hold);
        cmd_valid = 1'b1;
        tick();
        chk({tag, ":accept_tx"}, 32'(tx_out), 32'd0);
        chk({tag, ":accept_busy"}, 32'(busy), 32'd1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Called in the first cycle after accept; records the line until busy drops.
    task automatic capture(input string tag, input int n_bytes, input bit pe,
                           input logic [31:0] exp_bytes, input logic [3:0] exp_par,
                           input bit disturb);
        logic       line [0:2047];
        logic [7:0] got_byte;
        int len, cyc, n_bd, n_cd, last_bd, cd_cyc, base;
        len = (10 + int'(pe)) * CPB;
        cyc = 0; n_bd = 0; n_cd = 0; last_bd = -1; cd_cyc = -2;
        while (busy === 1'b1 && cyc < 2000) begin
            line[cyc] = tx_out;
            if (byte_done === 1'b1) begin n_bd++; last_bd = cyc; end
            if (cmd_done === 1'b1)  begin n_cd++; cd_cyc = cyc; end
            if (disturb && cyc == 10) begin
                cmd_valid = 1'b1;
                par_typ   = ~par_typ;
                par_en    = 1'b0;
                cmd_type  = 2'd3;
                cmd_data0 = 8'hFF;
            end
            if (disturb && cyc == 11) cmd_valid = 1'b0;
            tick();
            cyc++;
        end
        chk({tag, ":busy_cycles"}, 32'(cyc), 32'(n_bytes * len));
        chk({tag, ":byte_done_cnt"}, 32'(n_bd), 32'(n_bytes));
        chk({tag, ":cmd_done_cnt"}, 32'(n_cd), 32'd1);
        chk({tag, ":cmd_done_pos"}, 32'(cd_cyc), 32'(n_bytes * len - 1));
        chk({tag, ":cmd_done_with_last_bd"}, 32'(cd_cyc), 32'(last_bd));
        for (int j = 0; j < n_bytes; j++) begin
            base = j * len;
            got_byte = '0;
            for (int b = 0; b < 8; b++) got_byte[b] = line[base + (1 + b) * CPB + CPB / 2];
            chk($sformatf("%s:b%0d_start", tag, j), 32'(line[base + CPB / 2]), 32'd0);
            chk($sformatf("%s:b%0d_data", tag, j), 32'(got_byte), 32'(exp_bytes[8*j +: 8]));
            if (pe) chk($sformatf("%s:b%0d_parity", tag, j),
                        32'(line[base + 9 * CPB + CPB / 2]), 32'(exp_par[j]));
            chk($sformatf("%s:b%0d_stop", tag, j),
                32'(line[base + (9 + int'(pe)) * CPB + CPB / 2]), 32'd1);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1;
        cmd_valid = 1'b1;
        set_cmd(2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 1'b0, 1'b0);

        // Reset held with cmd_valid high: nothing is accepted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst%0d_tx", i), 32'(tx_out), 32'd1);
            chk($sformatf("rst%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("rst%0d_ready", i), 32'(cmd_ready), 32'd0);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);
        chk("rst_release_busy", 32'(busy), 32'd0);

        // RF_WR, no parity: AA 03 5A, 3*10*4 = 120 cycles.
        tick();
        set_cmd(2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 1'b0, 1'b0);
        issue("rf_wr", 1'b0);
        capture("rf_wr", 3, 1'b0, 32'h005A03AA, 4'b0000, 1'b0);

        // ALU_OP, even parity: CC CC 01 09 -> parity 0,0,1,0; 4*11*4 = 176 cycles.
        tick();
        set_cmd(2'd2, 4'h0, 8'hCC, 8'h01, 4'h9, 1'b1, 1'b0);
        issue("alu_even", 1'b0);
        capture("alu_even", 4, 1'b1, 32'h0901CCCC, 4'b0100, 1'b0);

        // Same command, odd parity -> 1,1,0,1.
        tick();
        set_cmd(2'd2, 4'h0, 8'hCC, 8'h01, 4'h9, 1'b1, 1'b1);
        issue("alu_odd", 1'b0);
        capture("alu_odd", 4, 1'b1, 32'h0901CCCC, 4'b1011, 1'b0);

        // RF_RD then ALU_NOP with cmd_valid held: exactly one idle-high cycle between.
        tick();
        set_cmd(2'd1, 4'h5, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0);
        issue("b2b_rd", 1'b1);
        set_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'hE, 1'b0, 1'b0);
        capture("b2b_rd", 2, 1'b0, 32'h000005BB, 4'b0000, 1'b0);
        chk("b2b_gap_tx", 32'(tx_out), 32'd1);
        chk("b2b_gap_busy", 32'(busy), 32'd0);
        chk("b2b_gap_ready", 32'(cmd_ready), 32'd1);
        issue("b2b_nop", 1'b0);
        capture("b2b_nop", 2, 1'b0, 32'h00000EDD, 4'b0000, 1'b0);

        // Reset during data bit 5 of byte index 2 (0x5A bit5 = 0 on the line).
        tick();
        set_cmd(2'd0, 4'h3, 8'h5A, 8'h00, 4'h0, 1'b0, 1'b0);
        issue("abort", 1'b0);
        repeat (2 * 10 * CPB + 6 * CPB + 1) tick();
        chk("abort_pre_tx", 32'(tx_out), 32'd0);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_tx", 32'(tx_out), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_byte_done", 32'(byte_done), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        tick();
        set_cmd(2'd1, 4'h7, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1);
        issue("after_abort", 1'b0);
        capture("after_abort", 2, 1'b1, 32'h000007BB, 4'b0001, 1'b0);

        // Inputs wiggled mid-frame must not alter this frame or start another.
        tick();
        set_cmd(2'd0, 4'hC, 8'h81, 8'h00, 4'h0, 1'b1, 1'b0);
        issue("ignore", 1'b0);
        capture("ignore", 3, 1'b1, 32'h00810CAA, 4'b0000, 1'b1);
        seen = 0;
        repeat (20) begin
            if (busy !== 1'b0 || tx_out !== 1'b1) seen++;
            tick();
        end
        chk("ignore_no_extra_frame", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
